freq_tuning_word: RTL
=====================

# freq_tuning_word

Converts the instantaneous sweep frequency (Hz, 20-bit) into a 32-bit DDS phase-increment (tuning word) for the 100 MHz phase accumulator.
- Sits directly downstream of the sweep controller and upstream of the DDS phase accumulator.
- Uses a sequential shift-add multiplier, so no wide DSP multiply is needed.
- Converts only on change. The tuning word updates atomically with a one-cycle valid strobe.

## Interface
- `FREQ_W`, 20: input frequency width (Hz).
- `TW_W`, 32: tuning-word width.
- `TW_K`, 2814750: scale constant, round(2^48 / 100e6).
- `TW_SHIFT`, 16: right shift applied after rounding. Effective gain is K/2^16 = 42.9496765 per Hz.
- `RST_FREQ`, 100000: frequency assumed at reset; equals the sweep controller's reset output.
- `clk` in 1: 100 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `freq_in` in 20: current frequency in Hz, from the sweep stage.
- `tw_out` out 32: tuning word, held between updates. Reset value 32'd4294968.
- `freq_out` out 20: frequency that `tw_out` represents. Reset value 20'd100000.
- `tw_valid` out 1: one-cycle pulse when `tw_out`/`freq_out` update. Reset value 0.
- `busy` out 1: high while a conversion is in flight. Reset value 0.

## Operation
- **Registers:** `last_freq` (reset `RST_FREQ`), `op_freq`, 42-bit `acc`, 42-bit `mcand`, 5-bit `bit_cnt`.
- **FSM states:** IDLE, MUL, OUT.
- **IDLE:**
  - If `freq_in != last_freq`: latch `freq_in` into `op_freq` and `last_freq`; `acc` <= 0; `mcand` <= `TW_K`; `bit_cnt` <= 0; go to MUL.
  - Otherwise stay in IDLE.
- **MUL (20 cycles):**
  - Each cycle: if `op_freq[0]`, `acc` <= `acc + mcand`.
  - Then `mcand` <<= 1, `op_freq` >>= 1, `bit_cnt`++.
  - After the cycle where `bit_cnt == 19`, go to OUT.
- **OUT (1 cycle):**
  - `tw_out` <= (`acc` + 2^15) >> 16, truncated to 32 bits.
  - `freq_out` <= `last_freq`; `tw_valid` <= 1; go to IDLE.
- **Widths:**
  - `acc` is 42 bits: 20 + 22 bits, max product 1048575·2814750 < 2^42, so no overflow for any 20-bit input.
  - Result is < 2^26, so the 32-bit truncation never loses bits.
- **Input changes mid-conversion:** ignored until IDLE is re-entered. Only the value present in the first IDLE cycle is converted; intermediate values are skipped by design.
- **Back-to-back changes:** the next conversion starts the cycle after OUT, and `tw_valid` pulses are ≥22 cycles apart.
- **`busy`:** high in MUL and OUT, low in IDLE.
- **No clamping:** range limits are the sweep stage's job. `freq_in` = 0 yields `tw_out` = 0.
- **Reset mid-operation:** any state returns to IDLE. All outputs and `last_freq` take their reset values, and the partial result is discarded.

## Timing
- **Latency:** `freq_in` is sampled at edge E0 (IDLE→MUL). Multiply edges are E1–E20. The OUT edge E21 updates `tw_out`; `tw_valid` is high during the cycle after E21. Total latency is 21 clocks from the sampling edge.
- **Atomic update:** `tw_out`, `freq_out` and `tw_valid` change on the same edge; consumers latch on `tw_valid`.
- **Bandwidth:** max update rate is one per 22 cycles (4.5 MHz), which exceeds the sweep stage's 1 µs update rate.
- **Outputs:** all registered; no combinational path from input to output.

## Structure
- **Shared package `wavegen_pkg`:**
  - `SYS_CLK_HZ` = 100_000_000.
  - `FREQ_MIN` = 1000, `FREQ_MAX` = 999000.
  - `TW_K`, `TW_SHIFT`, `RST_FREQ`.
  - FSM state enum: IDLE, MUL, OUT.
- **Sub-module `seq_shift_add_mul`:**
  - Generic N×M unsigned serial multiplier.
  - Interface: `start`, `a`, `b`, `done`, `product`.
- **Top level:** holds change detection, rounding and the output registers.

## Test plan
- **Reset:** release reset with `freq_in` = 100000 → `tw_out` = 4294968, `freq_out` = 100000, no `tw_valid` pulse, `busy` = 0 indefinitely.
- **Low end:** `freq_in` 100000→1000 → after 21 clocks `tw_out` = 42950 with a single `tw_valid` pulse; `busy` high for exactly 21 cycles.
- **High end:** `freq_in` = 999000 → `tw_out` = 42906727, `freq_out` = 999000.
- **Change mid-conversion:** 1000, then 500000 at cycle 5, then 600000 at cycle 10 → first pulse gives 42950; second conversion starts the cycle after OUT; second pulse gives `tw_out` = 25769806, `freq_out` = 600000. 500000 is never output.
- **Reset mid-conversion:** assert `rst_n` at MUL cycle 10 → outputs return to reset values immediately. After release with `freq_in` = 250000 → one conversion, `tw_out` = 10737419.
- **Sweep-driven:** drive `freq_in` from the sweep controller in linear mode → every `tw_valid` matches a software model round(f·K/2^16). No pulse occurs while the frequency is constant.

Source files
------------

// File: rtl/wavegen_pkg.sv
// Shared constants and types for the waveform generator datapath.
// Sweep limits, DDS scaling and converter FSM states.
package wavegen_pkg;

   localparam int unsigned SYS_CLK_HZ = 100_000_000;
   localparam int unsigned FREQ_MIN   = 1000;
   localparam int unsigned FREQ_MAX   = 999000;

   // round(2^48 / SYS_CLK_HZ); divided by 2^16 after the multiply
   localparam int unsigned TW_K       = 2814750;
   localparam int unsigned TW_SHIFT   = 16;
   localparam int unsigned RST_FREQ   = 100000;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      OUT
   } ftw_state_e;

endpackage

// File: rtl/seq_shift_add_mul.sv
// Unsigned A_W x B_W serial multiplier, one multiplier bit per clock.
// done is high during the last accumulate cycle; product is final after it.
module seq_shift_add_mul #(
   parameter int A_W = 20,
   parameter int B_W = 22
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   output logic               done,
   output logic [A_W+B_W-1:0] product
);

   localparam int P_W   = A_W + B_W;
   localparam int CNT_W = (A_W > 1) ? $clog2(A_W) : 1;

   logic [A_W-1:0]   op;
   logic [P_W-1:0]   mcand;
   logic [P_W-1:0]   acc;
   logic [CNT_W-1:0] cnt;
   logic             run;
   logic             last_step;

   assign last_step = run && (cnt == CNT_W'(A_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op    <= '0;
         mcand <= '0;
         acc   <= '0;
         cnt   <= '0;
         run   <= 1'b0;
      end else if (start) begin
         op    <= a;
         mcand <= P_W'(b);
         acc   <= '0;
         cnt   <= '0;
         run   <= 1'b1;
      end else if (run) begin
         if (op[0]) begin
            acc <= acc + mcand;
         end
         mcand <= mcand << 1;
         op    <= op >> 1;
         cnt   <= cnt + 1'b1;
         if (last_step) begin
            run <= 1'b0;
         end
      end
   end

   assign done    = last_step;
   assign product = acc;

endmodule

// File: rtl/freq_tuning_word.sv
// Sweep frequency (Hz) to DDS tuning word, converted only on change.
// Result, frequency and valid strobe are updated together on one edge.
module freq_tuning_word #(
   parameter int          FREQ_W   = 20,
   parameter int          TW_W     = 32,
   parameter int unsigned TW_K     = wavegen_pkg::TW_K,
   parameter int unsigned TW_SHIFT = wavegen_pkg::TW_SHIFT,
   parameter int unsigned RST_FREQ = wavegen_pkg::RST_FREQ
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FREQ_W-1:0] freq_in,
   output logic [TW_W-1:0]   tw_out,
   output logic [FREQ_W-1:0] freq_out,
   output logic              tw_valid,
   output logic              busy
);

   import wavegen_pkg::*;

   localparam int K_W = $clog2(TW_K + 1);
   localparam int P_W = FREQ_W + K_W;

   // Reset tuning word matches what a conversion of RST_FREQ would give
   localparam logic [63:0] RST_PROD = 64'(RST_FREQ) * 64'(TW_K);
   localparam logic [63:0] RST_RND =
      (RST_PROD + (64'd1 << (TW_SHIFT - 1))) >> TW_SHIFT;
   localparam logic [TW_W-1:0]   RST_TW = TW_W'(RST_RND);
   localparam logic [FREQ_W-1:0] RST_F  = FREQ_W'(RST_FREQ);
   localparam logic [P_W-1:0]    HALF   = P_W'(1) << (TW_SHIFT - 1);

   ftw_state_e        state;
   ftw_state_e        state_nxt;
   logic [FREQ_W-1:0] last_freq;
   logic              start;
   logic              mul_done;
   logic [P_W-1:0]    product;
   logic [P_W-1:0]    rounded;

   assign start   = (state == IDLE) && (freq_in != last_freq);
   assign rounded = product + HALF;

   seq_shift_add_mul #(
      .A_W (FREQ_W),
      .B_W (K_W)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (freq_in),
      .b       (K_W'(TW_K)),
      .done    (mul_done),
      .product (product)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = MUL;
         MUL:     if (mul_done) state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_freq <= RST_F;
         tw_out    <= RST_TW;
         freq_out  <= RST_F;
         tw_valid  <= 1'b0;
      end else begin
         tw_valid <= 1'b0;
         if (start) begin
            last_freq <= freq_in;
         end
         if (state == OUT) begin
            tw_out   <= TW_W'(rounded >> TW_SHIFT);
            freq_out <= last_freq;
            tw_valid <= 1'b1;
         end
      end
   end

endmodule
